// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_wen;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request per handshake, fixed-latency access to a
// 64-bit word array, full aligned word returned on loads.
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [63:0]       addr_q, addr_nx;
   logic [63:0]       wdata_q, wdata_nx;
   logic [7:0]        wmask_q, wmask_nx;
   logic              wen_q, wen_nx;
   logic              req_ready_q, req_ready_nx;
   logic              resp_valid_q, resp_valid_nx;
   logic [63:0]       rdata_q, rdata_nx;
   logic              err_q, err_nx;

   logic [63:0]       off_c;
   logic [63:0]       word_off_c;
   logic [IDX_W-1:0]  idx_c;
   logic              range_err_c;
   logic              access_c;
   logic              mem_we_c;

   logic [63:0]       mem [DEPTH];

   // Range check on the full 64-bit word offset, before truncating to an index
   assign off_c       = addr_q - BASE_ADDR;
   assign word_off_c  = off_c >> 3;
   assign idx_c       = word_off_c[IDX_W-1:0];
   assign range_err_c = (addr_q < BASE_ADDR) || (word_off_c >= 64'(DEPTH));
   assign access_c    = (state == WAIT) && (cnt == '0);
   assign mem_we_c    = access_c && wen_q && !range_err_c;

   // Next-state and registered-output logic
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      addr_nx       = addr_q;
      wdata_nx      = wdata_q;
      wmask_nx      = wmask_q;
      wen_nx        = wen_q;
      resp_valid_nx = resp_valid_q;
      rdata_nx      = rdata_q;
      err_nx        = err_q;

      case (state)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_nx  = bus.req_addr;
               wdata_nx = bus.req_wdata;
               wmask_nx = bus.req_wmask;
               wen_nx   = bus.req_wen;
               cnt_nx   = CNT_W'(LATENCY - 1);
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nx = cnt - CNT_W'(1);
            end else begin
               state_nx      = RESP;
               resp_valid_nx = 1'b1;
               err_nx        = range_err_c;
               rdata_nx      = (!wen_q && !range_err_c) ? mem[idx_c] : 64'h0;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nx      = IDLE;
               resp_valid_nx = 1'b0;
               rdata_nx      = 64'h0;
               err_nx        = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Ready is a register so it never depends combinationally on req_valid
      req_ready_nx = (state_nx == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         wen_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         addr_q       <= addr_nx;
         wdata_q      <= wdata_nx;
         wmask_q      <= wmask_nx;
         wen_q        <= wen_nx;
         req_ready_q  <= req_ready_nx;
         resp_valid_q <= resp_valid_nx;
         rdata_q      <= rdata_nx;
         err_q        <= err_nx;
      end
   end

   // Storage is intentionally not reset; byte-lane masked write
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int i = 0; i < 8; i++) begin
            if (wmask_q[i]) begin
               mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dmem_responder;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 1024;

   typedef struct packed {
      logic [63:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   bit          sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [63:0] req_addr  = '0;
   logic        req_wen   = 1'b0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic        resp_ready = 1'b1;

   logic        req_ready_o, resp_valid_o, resp_err_o;
   logic [63:0] resp_rdata_o;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic [63:0] model [2][DEPTH];

   dmem_responder_if if0 ();
   dmem_responder_if if1 ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
      .clk(clk), .rst(rst), .bus(if0));
   dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
      .clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   assign if0.req_valid  = req_valid & ~sel;
   assign if1.req_valid  = req_valid & sel;
   assign if0.req_addr   = req_addr;
   assign if1.req_addr   = req_addr;
   assign if0.req_wen    = req_wen;
   assign if1.req_wen    = req_wen;
   assign if0.req_wdata  = req_wdata;
   assign if1.req_wdata  = req_wdata;
   assign if0.req_wmask  = req_wmask;
   assign if1.req_wmask  = req_wmask;
   assign if0.resp_ready = resp_ready;
   assign if1.resp_ready = resp_ready;

   assign req_ready_o  = sel ? if1.req_ready  : if0.req_ready;
   assign resp_valid_o = sel ? if1.resp_valid : if0.resp_valid;
   assign resp_rdata_o = sel ? if1.resp_rdata : if0.resp_rdata;
   assign resp_err_o   = sel ? if1.resp_err   : if0.resp_err;

   // One full transaction on instance s; hold>0 applies response backpressure
   task automatic do_txn(input bit s, input logic [63:0] a, input logic we,
                         input logic [63:0] wd, input logic [7:0] wm,
                         input int hold, input string name);
      logic [63:0] off, widx, exp_d, held_d;
      logic        exp_e, held_e;
      int          lat, cyc;
      exp_t        ex;
      lat   = s ? 1 : 2;
      off   = a - BASE;
      widx  = off >> 3;
      exp_e = (a < BASE) || (widx >= 64'(DEPTH));
      exp_d = 64'h0;
      if (!exp_e && !we) exp_d = model[s][widx[9:0]];
      if (!exp_e && we)
         for (int i = 0; i < 8; i++)
            if (wm[i]) model[s][widx[9:0]][8*i +: 8] = wd[8*i +: 8];
      sb.push_back('{d: exp_d, e: exp_e});

      sel = s;
      resp_ready = (hold == 0);
      @(negedge clk);
      vectors++;
      if (req_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_before: got %b want 1", name, req_ready_o);
      end
      req_addr = a; req_wen = we; req_wdata = wd; req_wmask = wm; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wen   = ~we;
      req_wmask = 8'hFF;

      for (cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         if (resp_valid_o === 1'b1) break;
      end
      vectors++;
      if (cyc != lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
      end
      ex = sb.pop_front();
      vectors++;
      if (resp_rdata_o !== ex.d || resp_err_o !== ex.e) begin
         miscompares++;
         $display("FAIL %s resp: got %h/%b want %h/%b", name, resp_rdata_o, resp_err_o, ex.d, ex.e);
      end

      held_d = resp_rdata_o;
      held_e = resp_err_o;
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            req_addr = BASE; req_wen = 1'b0; req_valid = 1'b1;
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         vectors++;
         if (resp_valid_o !== 1'b1 || resp_rdata_o !== held_d || resp_err_o !== held_e ||
             req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s hold%0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                     name, h, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o, held_d, held_e);
         end
      end
      resp_ready = 1'b1;

      @(posedge clk); #1;
      vectors++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || resp_rdata_o !== 64'h0 ||
          resp_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done: got v=%b rdy=%b d=%h e=%b want v=0 rdy=1 d=0 e=0",
                  name, resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         vectors++;
         if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s no_accept: got v=%b rdy=%b want v=0 rdy=1", name, resp_valid_o, req_ready_o);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0 || if0.resp_rdata !== 64'h0 ||
          if0.resp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset0: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                  if0.req_ready, if0.resp_valid, if0.resp_rdata, if0.resp_err);
      end
      vectors++;
      if (if1.req_ready !== 1'b1 || if1.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset1: got rdy=%b v=%b want 1 0", if1.req_ready, if1.resp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      do_txn(0, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, "st_full");
      do_txn(0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 0, "ld_full");
   endtask

   task automatic test_partial();
      do_txn(0, 64'h8000_0018, 1'b1, 64'h0, 8'hFF, 0, "st_zero");
      do_txn(0, 64'h8000_0018, 1'b1, 64'h0000_0000_00AB_0000, 8'h04, 0, "st_b2");
      do_txn(0, 64'h8000_0018, 1'b1, 64'hCDEF_0000_0000_0000, 8'hC0, 0, "st_b67");
      do_txn(0, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 0, "ld_partial");
      do_txn(0, 64'h8000_0018, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 0, "st_nomask");
      do_txn(0, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 0, "ld_nomask");
   endtask

   task automatic test_backpressure();
      do_txn(0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 5, "ld_bp");
   endtask

   task automatic test_range();
      do_txn(0, 64'h8000_1FF8, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0, "st_last");
      do_txn(0, 64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, 0, "ld_below");
      do_txn(0, 64'h8000_2000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "st_above");
      do_txn(0, 64'h0000_0001_8000_1FF8, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, "st_far");
      do_txn(0, 64'h8000_1FF8, 1'b0, 64'h0, 8'h00, 0, "ld_last");
   endtask

   task automatic test_low_bits();
      do_txn(0, 64'h8000_0013, 1'b0, 64'h0, 8'h00, 0, "ld_lowbits");
   endtask

   task automatic test_reset_mid(input bit s);
      do_txn(s, 64'h8000_0020, 1'b1, 64'h0, 8'hFF, 0, "st_clear");
      sel = s;
      resp_ready = 1'b1;
      @(negedge clk);
      req_addr = 64'h8000_0020; req_wen = 1'b1; req_wdata = '1; req_wmask = 8'hFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (req_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL abort%0d in_wait: got rdy=%b want 0", s, req_ready_o);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 64'h0 ||
          resp_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL abort%0d async: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                  s, req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
      end
      @(negedge clk);
      rst = 1'b0;
      do_txn(s, 64'h8000_0020, 1'b0, 64'h0, 8'h00, 0, "ld_after_abort");
   endtask

   task automatic test_latency1();
      do_txn(1, 64'h8000_0040, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "l1_st");
      do_txn(1, 64'h8000_0040, 1'b1, 64'h5500_0000_0000_0000, 8'h80, 0, "l1_st_b7");
      do_txn(1, 64'h8000_0040, 1'b0, 64'h0, 8'h00, 0, "l1_ld");
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial();
      test_backpressure();
      test_range();
      test_low_bits();
      test_reset_mid(1'b0);
      test_latency1();
      test_reset_mid(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
